if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the ARM 5-stage pipeline.
- Directly upstream of ID, which hosts the hazard detection unit; its `hazard` output drives `freeze` here.
- Holds the PC, issues requests to instruction memory over a req/ready handshake, and loads IF/ID.
- Honours freeze (hazard stall) and branch flush from EXE.

Parameters:
- ADDR_W, 32, PC/address width.
- INST_W, 32, instruction width.
- RESET_PC, 0, PC value after reset.
- PC_INC, 4, PC increment per fetched instruction.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-low
- freeze  in  1  from hazard detection; hold IF/ID and PC
- branch_taken  in  1  from EXE; redirect fetch, flush IF/ID
- branch_addr  in  ADDR_W  redirect target
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  fetch address; stable while imem_req=1 and imem_ready=0
- imem_ready  in  1  rdata valid this cycle; completes request
- imem_rdata  in  INST_W  fetched instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  ADDR_W  PC+PC_INC of held instruction (ARM PC-relative convention)
- if_id_inst  out  INST_W  held instruction

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=IDLE.
  - if_id_valid=0, if_id_pc=0, if_id_inst=0.
  - skid empty, target_q=0, imem_req=0.
- States:
  - IDLE: imem_req=0. Next cycle → REQ. Reachable only from reset.
  - REQ: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0. A fetched instruction sits in the skid register because freeze was high.
  - DRAIN: imem_req=1, imem_addr=pc (old). Completes an abandoned request; its data is discarded.
- Priority (highest first): branch_taken > freeze > normal flow.
- REQ, imem_ready=1, no branch:
  - freeze=0: IF/ID ← {1, pc+PC_INC, imem_rdata}; pc ← pc+PC_INC; stay REQ. Sustains 1 instr/cycle.
  - freeze=1: skid ← {pc+PC_INC, imem_rdata}; pc ← pc+PC_INC; → HOLD. IF/ID unchanged.
- REQ, imem_ready=0, no branch:
  - freeze=0: if_id_valid ← 0 (bubble).
  - freeze=1: IF/ID unchanged.
  - Address stays stable; stay REQ.
- HOLD:
  - freeze=1: stay; IF/ID unchanged.
  - freeze=0: IF/ID ← {1, skid}; → REQ.
- branch_taken=1 (any state): if_id_valid ← 0 regardless of freeze. Skid is dropped. Then:
  - REQ with imem_ready=1: rdata discarded; pc ← branch_addr; stay REQ.
  - REQ with imem_ready=0: target_q ← branch_addr; → DRAIN.
  - HOLD or IDLE: pc ← branch_addr; → REQ.
  - DRAIN: target_q ← branch_addr (latest wins); stay DRAIN unless imem_ready=1, then pc ← branch_addr, → REQ.
- DRAIN, no branch:
  - imem_ready=1: discard rdata; pc ← target_q; → REQ.
  - Otherwise stay. IF/ID stays invalid.
- Handshake: once imem_req=1, imem_addr must not change until a cycle with imem_ready=1. imem_ready while imem_req=0 is ignored.
- Latency: combinational ready memory gives instruction at address A in IF/ID on the edge after the request cycle.
- Arithmetic: pc+PC_INC wraps modulo 2^ADDR_W with no flag.
- Flushed IF/ID keeps its stale pc/inst fields; only if_id_valid is meaningful.
- if_id_inst/if_id_pc update only on valid loads.

Decomposition:
- Package arm_pipe_pkg: ADDR_W/INST_W defaults, fetch state encoding (IDLE, REQ, HOLD, DRAIN), PC_INC, NOP encoding 32'hE1A00000 for debug.
- Sub-module if_id_reg holds {valid, pc, inst} with load, flush, freeze controls. Flush overrides freeze.
- FSM, PC, skid and target_q live in the top.

Test Plan:
- Reset release, imem_ready tied 1, freeze=0 → imem_addr 0,4,8,…; if_id_pc 4,8,12 one cycle behind; if_id_valid=1 from the 2nd cycle after IDLE.
- freeze=1 for 3 cycles while a fetch of addr 8 completes → HOLD; imem_req=0; IF/ID keeps addr-4 instruction; after release, IF/ID = {1, 12, mem[8]}, then fetch 12.
- imem_ready low 2 cycles at addr 0x10 → imem_addr held 0x10; if_id_valid=0 both cycles; then IF/ID = {1, 0x14, mem[0x10]}.
- branch_taken to 0x100 while REQ at 0x20 with imem_ready=0, ready 2 cycles later → DRAIN holds 0x20; data discarded; next request 0x100; if_id_valid=0 throughout.
- branch_taken and freeze simultaneously in HOLD, target 0x40 → if_id_valid=0 next edge; skid dropped; next imem_addr=0x40.
- rst asserted mid-DRAIN → immediate IDLE; all outputs 0; after release first imem_addr=RESET_PC; pc at 0xFFFFFFFC wraps to 0.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared types and defaults for the ARM 5-stage pipeline front end.
package arm_pipe_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INST_W = 32;
    localparam int DEF_PC_INC = 4;

    // MOV r0, r0 -- handy when dumping a flushed IF/ID in a debugger
    localparam logic [31:0] NOP_INST = 32'hE1A0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: {valid, pc, inst} with load, freeze and flush.
module if_id_reg #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] d_pc,
    input  logic [INST_W-1:0] d_inst,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic [INST_W-1:0] inst
);

    // flush beats freeze; pc/inst are left stale when the entry is killed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (!freeze) begin
            if (load) begin
                valid <= 1'b1;
                pc    <= d_pc;
                inst  <= d_inst;
            end else begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC, imem req/ready handshake, skid for frozen fetches,
// drain of abandoned requests on branch, and the IF/ID register.
module if_fetch_stage
    import arm_pipe_pkg::*;
#(
    parameter int              ADDR_W   = DEF_ADDR_W,
    parameter int              INST_W   = DEF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              PC_INC   = DEF_PC_INC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              if_id_valid,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [INST_W-1:0] if_id_inst
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] target_q;
    logic [ADDR_W-1:0] skid_pc;
    logic [INST_W-1:0] skid_inst;
    logic              skid_valid;
    logic              req_q;

    assign pc_seq    = pc + ADDR_W'(PC_INC);
    assign imem_req  = req_q;
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            target_q   <= '0;
            skid_pc    <= '0;
            skid_inst  <= '0;
            skid_valid <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_REQ;
                    req_q <= 1'b1;
                    if (branch_taken) pc <= branch_addr;
                end
                ST_REQ: begin
                    if (branch_taken) begin
                        skid_valid <= 1'b0;
                        if (imem_ready) begin
                            pc <= branch_addr;
                        end else begin
                            // address must stay put until the memory answers
                            target_q <= branch_addr;
                            state    <= ST_DRAIN;
                        end
                    end else if (imem_ready) begin
                        pc <= pc_seq;
                        if (freeze) begin
                            skid_pc    <= pc_seq;
                            skid_inst  <= imem_rdata;
                            skid_valid <= 1'b1;
                            state      <= ST_HOLD;
                            req_q      <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (branch_taken || !freeze) begin
                        skid_valid <= 1'b0;
                        state      <= ST_REQ;
                        req_q      <= 1'b1;
                        if (branch_taken) pc <= branch_addr;
                    end
                end
                ST_DRAIN: begin
                    if (branch_taken) target_q <= branch_addr;
                    if (imem_ready) begin
                        pc    <= branch_taken ? branch_addr : target_q;
                        state <= ST_REQ;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    logic              ifid_load;
    logic              ifid_flush;
    logic [ADDR_W-1:0] ifid_d_pc;
    logic [INST_W-1:0] ifid_d_inst;

    assign ifid_load   = ((state == ST_REQ) && imem_ready) || ((state == ST_HOLD) && skid_valid);
    assign ifid_flush  = branch_taken || (state == ST_DRAIN);
    assign ifid_d_pc   = (state == ST_HOLD) ? skid_pc   : pc_seq;
    assign ifid_d_inst = (state == ST_HOLD) ? skid_inst : imem_rdata;

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_if_id (
        .clk    (clk),
        .rst    (rst),
        .load   (ifid_load),
        .flush  (ifid_flush),
        .freeze (freeze),
        .d_pc   (ifid_d_pc),
        .d_inst (ifid_d_inst),
        .valid  (if_id_valid),
        .pc     (if_id_pc),
        .inst   (if_id_inst)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus a randomized run checked
// against a program-order model of the delivered instruction stream.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;

    int checks = 0;
    int errors = 0;
    logic [31:0] salt = 32'h1357_9BDF;

    always #5 clk = ~clk;

    // instruction memory: combinational, content is a hash of the address
    assign imem_rdata = (imem_addr * 32'h9E37_79B1) ^ salt;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    if_fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_inst   (if_id_inst)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; imem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // reset, then fetch with ready=1 until imem_addr equals a (bounded)
    task automatic run_to(input logic [31:0] a);
        int n = 0;
        do_reset();
        imem_ready = 1'b1;
        tick();
        while (imem_addr !== a && n < 64) begin
            tick();
            n++;
        end
        checks++;
        if (imem_addr !== a) begin
            errors++;
            $display("FAIL run_to: imem_addr=%h required %h", imem_addr, a);
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr, if_id_valid, if_id_pc, if_id_inst} !== 98'd0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b addr=%h v=%b pc=%h inst=%h required all 0",
                     imem_req, imem_addr, if_id_valid, if_id_pc, if_id_inst);
        end
        @(negedge clk);
        rst = 1'b1;
        imem_ready = 1'b1;
        tick();
        checks++;
        if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_first_req: req=%b addr=%h v=%b required 1 0 0", imem_req, imem_addr, if_id_valid);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_req: req=%b required 0", imem_req);
        end
        imem_ready = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if ({imem_addr, if_id_valid, if_id_pc, if_id_inst} !==
                {32'(4 * i), 1'b1, 32'(4 * i), mem_f(32'(4 * (i - 1)))}) begin
                errors++;
                $display("FAIL seq_%0d: addr=%h v=%b pc=%h inst=%h required addr=%h pc=%h inst=%h", i,
                         imem_addr, if_id_valid, if_id_pc, if_id_inst, 32'(4 * i), 32'(4 * i), mem_f(32'(4 * (i - 1))));
            end
        end
    endtask

    task automatic test_freeze();
        run_to(32'h8);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({imem_req, if_id_valid, if_id_pc, if_id_inst} !== {1'b0, 1'b1, 32'h8, mem_f(32'h4)}) begin
                errors++;
                $display("FAIL freeze_hold_%0d: req=%b v=%b pc=%h inst=%h required req=0 v=1 pc=8 inst=%h",
                         i, imem_req, if_id_valid, if_id_pc, if_id_inst, mem_f(32'h4));
            end
        end
        freeze = 1'b0;
        tick();
        checks++;
        if ({imem_req, imem_addr, if_id_valid, if_id_pc, if_id_inst} !== {1'b1, 32'hC, 1'b1, 32'hC, mem_f(32'h8)}) begin
            errors++;
            $display("FAIL freeze_release: req=%b addr=%h v=%b pc=%h inst=%h required 1 c 1 c %h",
                     imem_req, imem_addr, if_id_valid, if_id_pc, if_id_inst, mem_f(32'h8));
        end
        tick();
        checks++;
        if ({imem_addr, if_id_pc, if_id_inst} !== {32'h10, 32'h10, mem_f(32'hC)}) begin
            errors++;
            $display("FAIL freeze_next: addr=%h pc=%h inst=%h required 10 10 %h", imem_addr, if_id_pc, if_id_inst, mem_f(32'hC));
        end
    endtask

    task automatic test_ready_stall();
        run_to(32'h10);
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h10, 1'b0}) begin
                errors++;
                $display("FAIL stall_%0d: req=%b addr=%h v=%b required 1 10 0", i, imem_req, imem_addr, if_id_valid);
            end
        end
        imem_ready = 1'b1;
        tick();
        checks++;
        if ({imem_addr, if_id_valid, if_id_pc, if_id_inst} !== {32'h14, 1'b1, 32'h14, mem_f(32'h10)}) begin
            errors++;
            $display("FAIL stall_release: addr=%h v=%b pc=%h inst=%h required 14 1 14 %h",
                     imem_addr, if_id_valid, if_id_pc, if_id_inst, mem_f(32'h10));
        end
    endtask

    task automatic test_branch_drain();
        run_to(32'h20);
        imem_ready = 1'b0; branch_taken = 1'b1; branch_addr = 32'h100;
        tick();
        branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h20, 1'b0}) begin
                errors++;
                $display("FAIL drain_%0d: req=%b addr=%h v=%b required 1 20 0", i, imem_req, imem_addr, if_id_valid);
            end
            if (i == 0) tick();
        end
        imem_ready = 1'b1;
        tick();
        checks++;
        if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h100, 1'b0}) begin
            errors++;
            $display("FAIL drain_done: req=%b addr=%h v=%b required 1 100 0", imem_req, imem_addr, if_id_valid);
        end
        tick();
        checks++;
        if ({if_id_valid, if_id_pc, if_id_inst} !== {1'b1, 32'h104, mem_f(32'h100)}) begin
            errors++;
            $display("FAIL drain_target: v=%b pc=%h inst=%h required 1 104 %h", if_id_valid, if_id_pc, if_id_inst, mem_f(32'h100));
        end
    endtask

    task automatic test_branch_in_hold();
        run_to(32'h8);
        freeze = 1'b1;
        tick();
        branch_taken = 1'b1; branch_addr = 32'h40;
        tick();
        branch_taken = 1'b0; freeze = 1'b0;
        checks++;
        if ({if_id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h40}) begin
            errors++;
            $display("FAIL hold_branch: v=%b req=%b addr=%h required 0 1 40", if_id_valid, imem_req, imem_addr);
        end
        tick();
        checks++;
        if ({if_id_valid, if_id_pc, if_id_inst} !== {1'b1, 32'h44, mem_f(32'h40)}) begin
            errors++;
            $display("FAIL hold_branch_target: v=%b pc=%h inst=%h required 1 44 %h", if_id_valid, if_id_pc, if_id_inst, mem_f(32'h40));
        end
    endtask

    task automatic test_reset_mid_drain();
        run_to(32'h20);
        imem_ready = 1'b0; branch_taken = 1'b1; branch_addr = 32'h200;
        tick();
        branch_taken = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr, if_id_valid, if_id_pc, if_id_inst} !== 98'd0) begin
            errors++;
            $display("FAIL drain_reset: req=%b addr=%h v=%b pc=%h inst=%h required all 0",
                     imem_req, imem_addr, if_id_valid, if_id_pc, if_id_inst);
        end
        @(negedge clk);
        rst = 1'b1;
        imem_ready = 1'b1;
        tick();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL drain_reset_restart: req=%b addr=%h required 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        run_to(32'h8);
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        checks++;
        if ({imem_addr, if_id_valid} !== {32'hFFFF_FFFC, 1'b0}) begin
            errors++;
            $display("FAIL wrap_req: addr=%h v=%b required fffffffc 0", imem_addr, if_id_valid);
        end
        tick();
        checks++;
        if ({imem_addr, if_id_valid, if_id_pc, if_id_inst} !== {32'h0, 1'b1, 32'h0, mem_f(32'hFFFF_FFFC)}) begin
            errors++;
            $display("FAIL wrap: addr=%h v=%b pc=%h inst=%h required 0 1 0 %h",
                     imem_addr, if_id_valid, if_id_pc, if_id_inst, mem_f(32'hFFFF_FFFC));
        end
    endtask

    // Program-order model: the next instruction ID should see is exp_next,
    // redirected by every taken branch; freeze holds IF/ID, branch kills it.
    task automatic test_random();
        logic [31:0] exp_next = 32'h0;
        logic [64:0] prev;
        logic        br, fz, pend;
        logic [31:0] tgt, paddr;
        int          delivered = 0;
        salt = $urandom;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            imem_ready   = ($urandom_range(0, 9) < 7);
            freeze       = ($urandom_range(0, 9) < 2);
            branch_taken = ($urandom_range(0, 19) == 0);
            branch_addr  = $urandom & 32'hFFFF_FFFC;
            #1;
            prev  = {if_id_valid, if_id_pc, if_id_inst};
            br    = branch_taken;
            fz    = freeze;
            tgt   = branch_addr;
            pend  = imem_req && !imem_ready;
            paddr = imem_addr;
            tick();
            if (pend) begin
                checks++;
                if ({imem_req, imem_addr} !== {1'b1, paddr}) begin
                    errors++;
                    $display("FAIL rnd_handshake cyc %0d: req=%b addr=%h required 1 %h", cyc, imem_req, imem_addr, paddr);
                end
            end
            checks++;
            if (br) begin
                if (if_id_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_branch_kill cyc %0d: v=%b required 0", cyc, if_id_valid);
                end
                exp_next = tgt;
            end else if (fz) begin
                if ({if_id_valid, if_id_pc, if_id_inst} !== prev) begin
                    errors++;
                    $display("FAIL rnd_freeze cyc %0d: ifid=%h required %h", cyc, {if_id_valid, if_id_pc, if_id_inst}, prev);
                end
            end else if (if_id_valid) begin
                if ({if_id_pc, if_id_inst} !== {exp_next + 32'd4, mem_f(exp_next)}) begin
                    errors++;
                    $display("FAIL rnd_order cyc %0d: pc=%h inst=%h required %h %h",
                             cyc, if_id_pc, if_id_inst, exp_next + 32'd4, mem_f(exp_next));
                end
                exp_next = exp_next + 32'd4;
                delivered++;
            end
        end
        checks++;
        if (delivered < 500) begin
            errors++;
            $display("FAIL rnd_progress: delivered %0d required at least 500", delivered);
        end
        freeze = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_freeze();
        test_ready_stall();
        test_branch_drain();
        test_branch_in_hold();
        test_reset_mid_drain();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
